decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, registered successor of the combinational instruction decoder. Sits between fetch and execute.
- Decodes each accepted instruction and stores the decoded bundle plus its PC in a DEPTH-entry FIFO.
- Fetch and execute sides each use a valid/ready handshake.
- Adds flush support and a halt-drain state machine.

Parameters:
- RA_W, 4, register address width; instruction width IW = RA_W+4.
- PC_W, 8, width of PC carried with each instruction.
- DEPTH, 2, FIFO entries (>=1).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction
- in_instr  in  IW  instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  discard all buffered/incoming instructions
- out_valid  out  1  FIFO head valid
- out_ready  in  1  execute consumes head
- out_pc  out  PC_W  head PC
- out_use_ra, out_use_rt, out_use_rw  out  1 each  operand/write enables
- out_rt_addr, out_rw_addr  out  RA_W each  register addresses
- out_read_ps, out_write_ps  out  1 each  predicate read/write
- out_use_immdt  out  1  immediate valid
- out_immdt  out  IW-2  immediate field
- out_jump, out_branch, out_interrupt, out_halt  out  1 each  control flags
- out_alu_op  out  nand_cpu_pkg::ALU_OP  ALU operation
- halted  out  1  core halted
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Field layout:
  - opcode = instr[IW-1:IW-4]; operand = instr[RA_W-1:0].
  - LI is selected by instr[IW-1:IW-2]=2'b10; its immediate is instr[IW-3:0].
- Decode table (priority order):
  - instr==0: CL.
  - 0000: CP.
  - 0001: NND.
  - 0010: LS.
  - 0011: RS.
  - 0100: EQ, write_ps.
  - 0101: NE, write_ps.
  - 0110: BR, read_ps, branch.
  - 0111: JRL, jump, rw=operand.
  - 10xx: LI.
  - 1100: LD.
  - 1101: ST.
  - 1110: INT, interrupt.
  - 1111: HLT, halt.
- Operand and register defaults:
  - use_ra/use_rt/use_rw per instruction class.
  - rt_addr = operand for every instruction.
  - rw_addr = 0 except CP/JRL, where rw_addr = operand.
  - use_immdt = 1 for LI/INT/HLT.
  - immdt = instr[IW-3:0] always.
  - alu_op = ALU_CLR for non-ALU instructions (BR, JRL, LD, ST, INT, HLT); no X on any output.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Accepted at edge N: visible at the head from cycle N+1 if the FIFO was empty.
- Ready and valid generation:
  - in_ready = (count<DEPTH) && state==RUN; it does not depend on same-cycle pop.
  - out_valid = count!=0. Head outputs are stable while out_valid && !out_ready.
- Push and pop in the same cycle: count unchanged, order preserved. FIFO pointers wrap modulo DEPTH.
- State machine (state is internal):
  - RUN: accepting. Accepting a HLT -> DRAIN.
  - DRAIN: in_ready=0. Popping the HLT entry -> HALTED.
  - HALTED: in_ready=0, halted=1, FIFO empty. Exit only by reset.
- Flush:
  - At the next edge: count=0, pointers=0; any same-cycle accept is discarded; any same-cycle pop still completes.
  - DRAIN -> RUN. HALTED is unaffected.
- Reset (async assert, sync deassert): state=RUN, count=0, out_valid=0, halted=0, in_ready=1 after release. All head field outputs read 0; alu_op=ALU_CLR.
- INT needs no state change; it is flagged only.

Optional Feature:
- Macro: DECODE_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_decoded (32b) and perf_stall (32b), both 0 at reset, saturating at all-ones.
  - perf_decoded increments on every pop.
  - perf_stall increments every cycle with in_valid && !in_ready && state==RUN.
  - Flush does not clear either counter.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then push 0x00, 0x05, 0x13, 0xA7 with out_ready=1 (RA_W=4). Required per-instruction response:
  - 0x00: CL, alu_op ALU_CLR, use_rw=1, rw=0.
  - 0x05: CP, rw_addr=5, use_ra=1.
  - 0x13: NND, rt=3.
  - 0xA7: LI, use_immdt=1, immdt=0x27.
  - Each appears one cycle after acceptance.
- Backpressure: DEPTH=2, out_ready=0, push 3 instructions -> count=2, in_ready=0 after 2nd, third held by fetch. Raise out_ready -> order preserved, third accepted on the freed slot.
- Push 0x61 (BR) then 0x72 (JRL) -> first: branch=1, read_ps=1, rt=1, alu_op=ALU_CLR. Second: jump=1, use_rw=1, rw=2.
- Push 0xF0 -> DRAIN, in_ready=0. Flush before pop -> state RUN, count=0, in_ready=1. Push 0xF0 again and pop -> halted=1 next cycle; in_ready stays 0 until n_rst is asserted.
- Assert n_rst low mid-stream with count=2 -> immediately out_valid=0, count=0, halted=0. After release, accepts new instruction.
- RA_W=6 (IW=10): push 10'b0111_101101 -> jump=1, rw_addr=45. Push 10'b10_11110000 -> LI, immdt=0xF0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder feeding a DEPTH-entry FIFO, with flush and halt-drain FSM.
// Optional performance counters are compiled in when DECODE_STAGE_PERF_EN is defined.
package nand_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_CLR, ALU_CP, ALU_NAND, ALU_LS, ALU_RS, ALU_EQ, ALU_NE, ALU_LI
  } ALU_OP;
endpackage

// state  | meaning
// RUN    | accepting instructions from fetch
// DRAIN  | HLT buffered; no accepts, emptying the FIFO
// HALTED | HLT consumed; core halted until reset
module decode_stage #(
  parameter int RA_W  = 4,
  parameter int PC_W  = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RA_W+3:0]              in_instr,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_use_ra,
  output logic                         out_use_rt,
  output logic                         out_use_rw,
  output logic [RA_W-1:0]              out_rt_addr,
  output logic [RA_W-1:0]              out_rw_addr,
  output logic                         out_read_ps,
  output logic                         out_write_ps,
  output logic                         out_use_immdt,
  output logic [RA_W+1:0]              out_immdt,
  output logic                         out_jump,
  output logic                         out_branch,
  output logic                         out_interrupt,
  output logic                         out_halt,
  output nand_cpu_pkg::ALU_OP          out_alu_op,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]                  perf_decoded,
  output logic [31:0]                  perf_stall
`endif
);
  import nand_cpu_pkg::*;

  localparam int IW    = RA_W + 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            use_ra;
    logic            use_rt;
    logic            use_rw;
    logic [RA_W-1:0] rt_addr;
    logic [RA_W-1:0] rw_addr;
    logic            read_ps;
    logic            write_ps;
    logic            use_immdt;
    logic [IW-3:0]   immdt;
    logic            jump;
    logic            branch;
    logic            interrupt;
    logic            halt;
    ALU_OP           alu_op;
  } dec_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  dec_t             mem_q [DEPTH];
  dec_t             dec, head;
  logic             push, pop;
  logic [3:0]       opc;
  logic [RA_W-1:0]  operand;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign opc     = in_instr[IW-1:IW-4];
  assign operand = in_instr[RA_W-1:0];

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rt_addr   = operand;
    dec.immdt     = in_instr[IW-3:0];
    dec.alu_op    = ALU_CLR;
    if (in_instr == '0) begin
      dec.use_rw = 1'b1;
    end else begin
      case (opc)
        4'b0000: begin dec.use_ra = 1'b1; dec.use_rw = 1'b1; dec.rw_addr = operand; dec.alu_op = ALU_CP; end
        4'b0001: begin dec.use_ra = 1'b1; dec.use_rt = 1'b1; dec.use_rw = 1'b1; dec.alu_op = ALU_NAND; end
        4'b0010: begin dec.use_ra = 1'b1; dec.use_rw = 1'b1; dec.alu_op = ALU_LS; end
        4'b0011: begin dec.use_ra = 1'b1; dec.use_rw = 1'b1; dec.alu_op = ALU_RS; end
        4'b0100: begin dec.use_ra = 1'b1; dec.use_rt = 1'b1; dec.write_ps = 1'b1; dec.alu_op = ALU_EQ; end
        4'b0101: begin dec.use_ra = 1'b1; dec.use_rt = 1'b1; dec.write_ps = 1'b1; dec.alu_op = ALU_NE; end
        4'b0110: begin dec.use_rt = 1'b1; dec.read_ps = 1'b1; dec.branch = 1'b1; end
        4'b0111: begin dec.use_rt = 1'b1; dec.use_rw = 1'b1; dec.rw_addr = operand; dec.jump = 1'b1; end
        4'b1100: begin dec.use_rt = 1'b1; dec.use_rw = 1'b1; end
        4'b1101: begin dec.use_ra = 1'b1; dec.use_rt = 1'b1; end
        4'b1110: begin dec.use_immdt = 1'b1; dec.interrupt = 1'b1; end
        4'b1111: begin dec.use_immdt = 1'b1; dec.halt = 1'b1; end
        default: begin dec.use_rw = 1'b1; dec.use_immdt = 1'b1; dec.alu_op = ALU_LI; end // 10xx: LI
      endcase
    end
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Head fields are forced to zero while empty so nothing undefined leaks out.
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push && dec.halt && !flush) state_d = DRAIN;
      DRAIN:   if (flush) state_d = RUN;
               else if (pop && head.halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= RUN;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= dec;
  end

  assign out_pc        = head.pc;
  assign out_use_ra    = head.use_ra;
  assign out_use_rt    = head.use_rt;
  assign out_use_rw    = head.use_rw;
  assign out_rt_addr   = head.rt_addr;
  assign out_rw_addr   = head.rw_addr;
  assign out_read_ps   = head.read_ps;
  assign out_write_ps  = head.write_ps;
  assign out_use_immdt = head.use_immdt;
  assign out_immdt     = head.immdt;
  assign out_jump      = head.jump;
  assign out_branch    = head.branch;
  assign out_interrupt = head.interrupt;
  assign out_halt      = head.halt;
  assign out_alu_op    = head.alu_op;
  assign halted        = (state_q == HALTED);
  assign count         = count_q;

`ifdef DECODE_STAGE_PERF_EN
  logic [31:0] perf_decoded_q, perf_stall_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop && perf_decoded_q != '1) perf_decoded_q <= perf_decoded_q + 32'd1;
      if (in_valid && !in_ready && state_q == RUN && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance (RA_W=4, DEPTH=2) plus an RA_W=6 instance.
module tb_decode_stage;
  import nand_cpu_pkg::*;

  logic clk, n_rst;
  int tests = 0;
  int fails = 0;

  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0] in_instr, in_pc, out_pc;
  logic       use_ra, use_rt, use_rw, read_ps, write_ps, use_immdt;
  logic [3:0] rt_addr, rw_addr;
  logic [5:0] immdt;
  logic       jump, branch, interrupt, halt, halted;
  ALU_OP      alu_op;
  logic [1:0] count;

  logic       i6_valid, i6_ready, i6_flush, o6_valid, o6_ready;
  logic [9:0] i6_instr;
  logic [7:0] i6_pc, o6_pc;
  logic       o6_use_ra, o6_use_rt, o6_use_rw, o6_read_ps, o6_write_ps, o6_use_immdt;
  logic [5:0] o6_rt_addr, o6_rw_addr;
  logic [7:0] o6_immdt;
  logic       o6_jump, o6_branch, o6_interrupt, o6_halt, o6_halted;
  ALU_OP      o6_alu_op;
  logic [1:0] o6_count;
`ifdef DECODE_STAGE_PERF_EN
  logic [31:0] perf_decoded, perf_stall, p6_decoded, p6_stall;
`endif

  decode_stage #(.RA_W(4), .PC_W(8), .DEPTH(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_use_ra(use_ra), .out_use_rt(use_rt), .out_use_rw(use_rw), .out_rt_addr(rt_addr),
    .out_rw_addr(rw_addr), .out_read_ps(read_ps), .out_write_ps(write_ps),
    .out_use_immdt(use_immdt), .out_immdt(immdt), .out_jump(jump), .out_branch(branch),
    .out_interrupt(interrupt), .out_halt(halt), .out_alu_op(alu_op), .halted(halted),
    .count(count)
`ifdef DECODE_STAGE_PERF_EN
    , .perf_decoded(perf_decoded), .perf_stall(perf_stall)
`endif
  );

  decode_stage #(.RA_W(6), .PC_W(8), .DEPTH(2)) u_dut6 (
    .clk(clk), .n_rst(n_rst), .in_valid(i6_valid), .in_ready(i6_ready), .in_instr(i6_instr),
    .in_pc(i6_pc), .flush(i6_flush), .out_valid(o6_valid), .out_ready(o6_ready), .out_pc(o6_pc),
    .out_use_ra(o6_use_ra), .out_use_rt(o6_use_rt), .out_use_rw(o6_use_rw),
    .out_rt_addr(o6_rt_addr), .out_rw_addr(o6_rw_addr), .out_read_ps(o6_read_ps),
    .out_write_ps(o6_write_ps), .out_use_immdt(o6_use_immdt), .out_immdt(o6_immdt),
    .out_jump(o6_jump), .out_branch(o6_branch), .out_interrupt(o6_interrupt),
    .out_halt(o6_halt), .out_alu_op(o6_alu_op), .halted(o6_halted), .count(o6_count)
`ifdef DECODE_STAGE_PERF_EN
    , .perf_decoded(p6_decoded), .perf_stall(p6_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    i6_valid = 1'b0; i6_instr = '0; i6_pc = '0; i6_flush = 1'b0; o6_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_halted", halted, 0);
    check("rst_alu_op", alu_op, ALU_CLR);
    check("rst_pc", out_pc, 0);
    check("rst_use_rw", use_rw, 0);
    #3 n_rst = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // streaming decode, one instruction per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 8'h00; in_pc = 8'h10; tick();
    check("cl_valid", out_valid, 1);
    check("cl_pc", out_pc, 8'h10);
    check("cl_alu", alu_op, ALU_CLR);
    check("cl_use_rw", use_rw, 1);
    check("cl_rw", rw_addr, 0);
    in_instr = 8'h05; in_pc = 8'h11; tick();
    check("cp_count", count, 1);
    check("cp_pc", out_pc, 8'h11);
    check("cp_rw", rw_addr, 5);
    check("cp_use_ra", use_ra, 1);
    check("cp_alu", alu_op, ALU_CP);
    in_instr = 8'h13; in_pc = 8'h12; tick();
    check("nnd_rt", rt_addr, 3);
    check("nnd_rw", rw_addr, 0);
    check("nnd_alu", alu_op, ALU_NAND);
    in_instr = 8'hA7; in_pc = 8'h13; tick();
    check("li_use_immdt", use_immdt, 1);
    check("li_immdt", immdt, 6'h27);
    check("li_alu", alu_op, ALU_LI);
    in_valid = 1'b0; tick();
    check("drain_valid", out_valid, 0);
    check("drain_immdt", immdt, 0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 8'h11; in_pc = 8'h20; tick();
    check("bp1_count", count, 1);
    check("bp1_in_ready", in_ready, 1);
    in_instr = 8'h12; in_pc = 8'h21; tick();
    check("bp2_count", count, 2);
    check("bp2_in_ready", in_ready, 0);
    in_instr = 8'h14; in_pc = 8'h22; tick();
    check("bp3_count", count, 2);
    check("bp3_head_pc", out_pc, 8'h20);
    check("bp3_head_rt", rt_addr, 1);
    out_ready = 1'b1; tick();
    check("bp4_pc", out_pc, 8'h21);
    check("bp4_count", count, 1);
    check("bp4_in_ready", in_ready, 1);
    tick();
    check("bp5_pc", out_pc, 8'h22);
    check("bp5_rt", rt_addr, 4);
    check("bp5_count", count, 1);
    in_valid = 1'b0; tick();
    check("bp6_count", count, 0);

    // control-flow instructions
    in_valid = 1'b1; in_instr = 8'h61; in_pc = 8'h30; tick();
    check("br_branch", branch, 1);
    check("br_read_ps", read_ps, 1);
    check("br_rt", rt_addr, 1);
    check("br_alu", alu_op, ALU_CLR);
    check("br_jump", jump, 0);
    in_instr = 8'h72; in_pc = 8'h31; tick();
    check("jrl_jump", jump, 1);
    check("jrl_use_rw", use_rw, 1);
    check("jrl_rw", rw_addr, 2);
    check("jrl_branch", branch, 0);
    in_instr = 8'hE3; in_pc = 8'h32; tick();
    check("int_flag", interrupt, 1);
    check("int_immdt", use_immdt, 1);
    check("int_alu", alu_op, ALU_CLR);
    in_instr = 8'h45; in_pc = 8'h33; tick();
    check("eq_write_ps", write_ps, 1);
    check("eq_alu", alu_op, ALU_EQ);
    in_valid = 1'b0; tick();

    // halt, flush out of DRAIN, then halt for real
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 8'hF0; in_pc = 8'h40; tick();
    check("hlt_in_ready", in_ready, 0);
    check("hlt_count", count, 1);
    check("hlt_flag", halt, 1);
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    in_valid = 1'b1; in_pc = 8'h41; tick();
    in_valid = 1'b0;
    check("hlt2_in_ready", in_ready, 0);
    check("hlt2_halted", halted, 0);
    out_ready = 1'b1; tick();
    check("halted_flag", halted, 1);
    check("halted_count", count, 0);
    check("halted_in_ready", in_ready, 0);
    in_valid = 1'b1; flush = 1'b1; tick(); tick();
    flush = 1'b0;
    check("halted_sticky", halted, 1);
    check("halted_ready_sticky", in_ready, 0);

    // async reset clears halt; then reset mid-stream with two entries buffered
    in_valid = 1'b0; out_ready = 1'b0;
    #2 n_rst = 1'b0; #1;
    check("arst_halted", halted, 0);
    #2 n_rst = 1'b1;
    in_valid = 1'b1; in_instr = 8'h21; in_pc = 8'h50; tick();
    in_instr = 8'h31; in_pc = 8'h51; tick();
    in_valid = 1'b0;
    check("pre_rst_count", count, 2);
    #2 n_rst = 1'b0; #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_halted", halted, 0);
    #2 n_rst = 1'b1;
    in_valid = 1'b1; in_instr = 8'h35; in_pc = 8'h60; tick();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_pc", out_pc, 8'h60);
    check("post_rst_alu", alu_op, ALU_RS);

    // wider register address
    o6_ready = 1'b1; i6_valid = 1'b1; i6_instr = 10'b0111_101101; i6_pc = 8'h70; tick();
    check("w6_jump", o6_jump, 1);
    check("w6_rw", o6_rw_addr, 45);
    check("w6_pc", o6_pc, 8'h70);
    i6_instr = 10'b10_11110000; i6_pc = 8'h71; tick();
    i6_valid = 1'b0;
    check("w6_li_alu", o6_alu_op, ALU_LI);
    check("w6_li_immdt", o6_immdt, 8'hF0);
    check("w6_li_use", o6_use_immdt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
